// File: rtl/freq_measure_scheduler_pkg.sv
// rtl/freq_measure_scheduler_pkg.sv - shared state encoding and sizing helpers for the frequency scheduler
package freq_measure_scheduler_pkg;

    localparam int CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIND,
        ST_CLEAR,
        ST_SETTLE,
        ST_DISCARD,
        ST_ACCUM,
        ST_EMIT
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/freq_measure_scheduler_if.sv
// rtl/freq_measure_scheduler_if.sv - control, counter and result signals of the frequency scheduler
interface freq_measure_scheduler_if #(
    parameter int NUM_CH = 8
);
    import freq_measure_scheduler_pkg::*;

    localparam int CH_W = ch_width(NUM_CH);

    logic              START;
    logic [NUM_CH-1:0] CH_MASK;
    logic              BUSY;
    logic              DONE;
    logic [CH_W-1:0]   SEL;
    logic              CNT_RST_N;
    logic              FREQ_SEL;
    logic [31:0]       PERIOD;
    logic              RES_VALID;
    logic              RES_READY;
    logic [CH_W-1:0]   RES_CH;
    logic [31:0]       RES_PERIOD;
    logic              RES_TIMEOUT;

    modport master (
        output START, CH_MASK, FREQ_SEL, PERIOD, RES_READY,
        input  BUSY, DONE, SEL, CNT_RST_N, RES_VALID, RES_CH, RES_PERIOD, RES_TIMEOUT
    );

    modport slave (
        input  START, CH_MASK, FREQ_SEL, PERIOD, RES_READY,
        output BUSY, DONE, SEL, CNT_RST_N, RES_VALID, RES_CH, RES_PERIOD, RES_TIMEOUT
    );

endinterface

// File: rtl/freq_edge_detect.sv
// rtl/freq_edge_detect.sv - falling-edge detector with a one-cycle-delayed sample strobe
module freq_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic din,
    output logic fall,
    output logic sample
);

    logic prev;

    assign fall = prev & ~din;

    // sample lags fall by one cycle so a counter updated on the same edge is already stable
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            prev   <= 1'b0;
            sample <= 1'b0;
        end else begin
            prev   <= din;
            sample <= fall;
        end
    end

endmodule

// File: rtl/freq_measure_scheduler.sv
// rtl/freq_measure_scheduler.sv - sweeps one shared frequency counter across masked oscillator channels
module freq_measure_scheduler #(
    parameter int NUM_CH        = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int DISCARD       = 3,
    parameter int AVG_LOG2      = 2,
    parameter int TIMEOUT       = 65535
) (
    input  logic CLK,
    input  logic RST,
    freq_measure_scheduler_if.slave bus
);
    import freq_measure_scheduler_pkg::*;

    localparam int CH_W    = ch_width(NUM_CH);
    localparam int NUM_AVG = 1 << AVG_LOG2;
    localparam int ACC_W   = 32 + AVG_LOG2;

    state_t            state;
    logic              busy, done, cnt_rst_n, res_valid, res_timeout;
    logic [CH_W-1:0]   sel, res_ch;
    logic [31:0]       res_period;
    logic [NUM_CH-1:0] mask;
    logic [1:0]        clr_cnt;
    logic [31:0]       settle_cnt, to_cnt, edge_cnt;
    logic [ACC_W-1:0]  acc, acc_next;
    logic              edge_clr, fall, sample, timed_out, acc_done;
    logic [CH_W:0]     next_ch;

    function automatic logic [CH_W:0] find_first(input logic [NUM_CH-1:0] m,
                                                 input logic [CH_W-1:0]   from);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i] && i >= int'(from))
                r = {1'b1, CH_W'(i)};
        return r;
    endfunction

    // Edges seen before DISCARD (including SETTLE) must never reach the counters
    assign edge_clr  = (state != ST_DISCARD) && (state != ST_ACCUM);
    assign next_ch   = find_first(mask, sel);
    assign acc_next  = acc + ACC_W'(bus.PERIOD);
    assign timed_out = !fall && (to_cnt == 32'(TIMEOUT - 1));
    assign acc_done  = (state == ST_ACCUM) && sample && (edge_cnt == 32'(NUM_AVG - 1));

    freq_edge_detect u_edge (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (edge_clr),
        .din    (bus.FREQ_SEL),
        .fall   (fall),
        .sample (sample)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            sel         <= '0;
            cnt_rst_n   <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_period  <= '0;
            res_timeout <= 1'b0;
            mask        <= '0;
            clr_cnt     <= '0;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            edge_cnt    <= '0;
            acc         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt_rst_n <= 1'b0;
                    if (bus.START) begin
                        mask  <= bus.CH_MASK;
                        busy  <= 1'b1;
                        sel   <= '0;
                        state <= ST_FIND;
                    end
                end
                ST_FIND: begin
                    cnt_rst_n <= 1'b0;
                    if (next_ch[CH_W]) begin
                        sel     <= next_ch[CH_W-1:0];
                        clr_cnt <= '0;
                        state   <= ST_CLEAR;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    edge_cnt <= '0;
                    acc      <= '0;
                    to_cnt   <= '0;
                    clr_cnt  <= clr_cnt + 2'd1;
                    if (clr_cnt == 2'(CLEAR_CYCLES - 1)) begin
                        cnt_rst_n  <= 1'b1;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 32'd1;
                    if (settle_cnt == 32'(SETTLE_CYCLES - 1))
                        state <= ST_DISCARD;
                end
                ST_DISCARD, ST_ACCUM: begin
                    to_cnt <= fall ? '0 : to_cnt + 32'd1;
                    if (state == ST_DISCARD) begin
                        if (sample) begin
                            if (edge_cnt == 32'(DISCARD - 1)) begin
                                edge_cnt <= '0;
                                state    <= ST_ACCUM;
                            end else begin
                                edge_cnt <= edge_cnt + 32'd1;
                            end
                        end
                    end else if (sample) begin
                        acc      <= acc_next;
                        edge_cnt <= edge_cnt + 32'd1;
                    end
                    if (acc_done) begin
                        res_period  <= acc_next[AVG_LOG2 +: 32];
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        res_ch      <= sel;
                        state       <= ST_EMIT;
                    end else if (timed_out) begin
                        res_period  <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        res_ch      <= sel;
                        state       <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.RES_READY) begin
                        res_valid <= 1'b0;
                        mask[sel] <= 1'b0;
                        state     <= ST_FIND;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.BUSY        = busy;
    assign bus.DONE        = done;
    assign bus.SEL         = sel;
    assign bus.CNT_RST_N   = cnt_rst_n;
    assign bus.RES_VALID   = res_valid;
    assign bus.RES_CH      = res_ch;
    assign bus.RES_PERIOD  = res_period;
    assign bus.RES_TIMEOUT = res_timeout;

endmodule

// File: tb/tb_freq_measure_scheduler.sv
// tb/tb_freq_measure_scheduler.sv - scoreboard bench for the frequency measurement scheduler
module tb_freq_measure_scheduler;

    localparam int NUM_CH  = 8;
    localparam int TIMEOUT = 100;

    typedef struct {
        int ch;
        int period;
        int to;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    freq_measure_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    freq_measure_scheduler #(
        .NUM_CH        (NUM_CH),
        .SETTLE_CYCLES (16),
        .DISCARD       (3),
        .AVG_LOG2      (2),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Oscillators: ch0 10/10, ch1 high 10 / low 10..13 cycling, ch2 25/25, ch7 stuck low, others 8/8
    logic [NUM_CH-1:0] osc;
    int rem [NUM_CH];
    int jit;

    function automatic int half_len(input int c, input logic lvl, input int j);
        case (c)
            0: return 10;
            1: return lvl ? 10 : 10 + j;
            2: return 25;
            default: return 8;
        endcase
    endfunction

    always @(negedge CLK) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == 7) begin
                osc[c] = 1'b0;
            end else if (rem[c] > 1) begin
                rem[c] = rem[c] - 1;
            end else begin
                osc[c] = ~osc[c];
                rem[c] = half_len(c, osc[c], jit);
                if (c == 1 && !osc[c]) jit = (jit + 1) % 4;
            end
        end
    end

    // Behavioural frequency counter: PERIOD updates on the edge where the fall is seen
    logic        c_prev = 1'b0;
    logic [31:0] c_cnt = '0;
    logic [31:0] c_period = '0;
    always @(posedge CLK) begin
        if (!bus.CNT_RST_N) begin
            c_prev   <= 1'b0;
            c_cnt    <= '0;
            c_period <= '0;
        end else begin
            c_prev <= bus.FREQ_SEL;
            if (c_prev && !bus.FREQ_SEL) begin
                c_period <= c_cnt + 32'd1;
                c_cnt    <= '0;
            end else begin
                c_cnt <= c_cnt + 32'd1;
            end
        end
    end

    assign bus.FREQ_SEL = osc[bus.SEL];
    assign bus.PERIOD   = c_period;

    always @(negedge CLK) begin
        exp_t e;
        if (bus.DONE === 1'b1) done_cnt++;
        if (RST === 1'b0 && bus.RES_VALID === 1'b1 && bus.RES_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(bus.RES_CH), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("res_ch", 32'(bus.RES_CH), e.ch);
                chk("res_period", bus.RES_PERIOD, e.period);
                chk("res_timeout", 32'(bus.RES_TIMEOUT), e.to);
            end
        end
    end

    task automatic expect_res(input int ch, input int period, input int to);
        exp_t e;
        e.ch = ch;
        e.period = period;
        e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic start_sweep(input logic [NUM_CH-1:0] m);
        @(posedge CLK);
        #1;
        bus.START   = 1'b1;
        bus.CH_MASK = m;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (bus.DONE !== 1'b1 && k < bound);
        if (bus.DONE !== 1'b1) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input int bound, input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (bus.RES_VALID !== 1'b1 && cyc < bound);
        if (bus.RES_VALID !== 1'b1) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_busy"}, 32'(bus.BUSY), 0);
        chk({p, "_done"}, 32'(bus.DONE), 0);
        chk({p, "_sel"}, 32'(bus.SEL), 0);
        chk({p, "_cnt_rst_n"}, 32'(bus.CNT_RST_N), 0);
        chk({p, "_res_valid"}, 32'(bus.RES_VALID), 0);
        chk({p, "_res_ch"}, 32'(bus.RES_CH), 0);
        chk({p, "_res_period"}, bus.RES_PERIOD, 0);
        chk({p, "_res_timeout"}, 32'(bus.RES_TIMEOUT), 0);
    endtask

    initial begin
        int          cyc;
        logic        stable;
        logic [2:0]  s_ch, s_sel;
        logic [31:0] s_per;
        logic        s_to;

        osc = '0;
        for (int c = 0; c < NUM_CH; c++) rem[c] = 1;
        jit = 0;
        RST = 1'b1;
        bus.START = 1'b0;
        bus.CH_MASK = '0;
        bus.RES_READY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset("rst");
        @(posedge CLK);
        #1 RST = 1'b0;

        // two channels back to back, consumer always ready
        done_cnt = 0;
        expect_res(0, 20, 0);
        expect_res(2, 50, 0);
        start_sweep(8'b0000_0101);
        wait_done(3000, "t1_done_timeout");
        @(negedge CLK);
        chk("t1_pending", exp_q.size(), 0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy", 32'(bus.BUSY), 0);

        // jittered channel averages four consecutive periods
        done_cnt = 0;
        expect_res(1, 21, 0);
        start_sweep(8'b0000_0010);
        wait_done(2000, "t2_done_timeout");
        @(negedge CLK);
        chk("t2_pending", exp_q.size(), 0);
        chk("t2_done_cnt", done_cnt, 1);

        // dead channel times out
        done_cnt = 0;
        expect_res(7, 0, 1);
        start_sweep(8'b1000_0000);
        wait_valid(400, "t3_valid_timeout", cyc);
        chk("t3_latency_in_window", 32'(cyc >= 110 && cyc <= 125), 1);
        wait_done(200, "t3_done_timeout");
        @(negedge CLK);
        chk("t3_pending", exp_q.size(), 0);

        // backpressure holds the result steady
        done_cnt = 0;
        bus.RES_READY = 1'b0;
        expect_res(0, 20, 0);
        start_sweep(8'b0000_0001);
        wait_valid(1000, "t4_valid_timeout", cyc);
        s_ch = bus.RES_CH;
        s_per = bus.RES_PERIOD;
        s_to = bus.RES_TIMEOUT;
        s_sel = bus.SEL;
        stable = 1'b1;
        repeat (50) begin
            @(negedge CLK);
            if (bus.RES_VALID !== 1'b1 || bus.RES_CH !== s_ch || bus.RES_PERIOD !== s_per ||
                bus.RES_TIMEOUT !== s_to || bus.SEL !== s_sel)
                stable = 1'b0;
        end
        chk("t4_stable", 32'(stable), 1);
        chk("t4_sel", 32'(s_sel), 0);
        chk("t4_held", exp_q.size(), 1);
        @(posedge CLK);
        #1 bus.RES_READY = 1'b1;
        wait_done(100, "t4_done_timeout");
        @(negedge CLK);
        chk("t4_pending", exp_q.size(), 0);
        chk("t4_done_cnt", done_cnt, 1);

        // empty mask finishes two cycles after START
        done_cnt = 0;
        start_sweep(8'b0000_0000);
        @(negedge CLK);
        chk("t5_done_early", 32'(bus.DONE), 0);
        chk("t5_busy", 32'(bus.BUSY), 1);
        @(negedge CLK);
        chk("t5_done", 32'(bus.DONE), 1);
        @(negedge CLK);
        chk("t5_busy_after", 32'(bus.BUSY), 0);
        chk("t5_done_cnt", done_cnt, 1);

        // START while busy is ignored
        done_cnt = 0;
        expect_res(0, 20, 0);
        start_sweep(8'b0000_0001);
        repeat (5) @(posedge CLK);
        start_sweep(8'b0000_1000);
        wait_done(1000, "t5b_done_timeout");
        repeat (100) @(negedge CLK);
        chk("t5b_pending", exp_q.size(), 0);
        chk("t5b_done_cnt", done_cnt, 1);

        // reset in the middle of ACCUM, then a clean sweep
        start_sweep(8'b0000_0101);
        repeat (100) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_reset("t6");
        chk("t6_no_result", exp_q.size(), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        done_cnt = 0;
        expect_res(0, 20, 0);
        expect_res(2, 50, 0);
        start_sweep(8'b0000_0101);
        wait_done(3000, "t6_done_timeout");
        @(negedge CLK);
        chk("t6_pending", exp_q.size(), 0);
        chk("t6_done_cnt", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_measure_scheduler.md
Name: freq_measure_scheduler

Overview:
Sequences one shared frequency_counter across NUM_CH ring-oscillator inputs. It drives the input mux select and the counter's active-low reset, and waits a settle time. It discards the invalid first periods, averages 2^AVG_LOG2 valid PERIOD samples, and returns one result per enabled channel over a valid/ready handshake. It sits between the readout/control interface and the counter instance.

Parameters:
NUM_CH, 8, number of oscillator channels (select width CH_W = clog2(NUM_CH), minimum 1)
SETTLE_CYCLES, 16, cycles held after mux switch and counter release before edges are counted
DISCARD, 3, falling edges ignored after counter release (counter PERIOD is invalid for the first two)
AVG_LOG2, 2, log2 of the number of PERIOD samples averaged
TIMEOUT, 65535, max cycles between consecutive falling edges before the channel is declared dead

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high
START  in  1  single-cycle request to begin a sweep; ignored while BUSY
CH_MASK  in  NUM_CH  channel enable bits, latched on accepted START
BUSY  out  1  high from accepted START until the DONE cycle
DONE  out  1  one-cycle pulse when the sweep completes
SEL  out  CH_W  mux select feeding FREQ_IN of the counter
CNT_RST_N  out  1  drives the counter RST_N
FREQ_SEL  in  1  same muxed signal the counter sees (used for edge detect)
PERIOD  in  32  counter PERIOD output
RES_VALID  out  1  result available
RES_READY  in  1  consumer accepts the result
RES_CH  out  CH_W  channel of the result
RES_PERIOD  out  32  averaged period in CLK cycles
RES_TIMEOUT  out  1  channel timed out; RES_PERIOD = 0

Behaviour:
- Reset (RST=1 at a CLK edge): state IDLE, BUSY=0, DONE=0, SEL=0, CNT_RST_N=0, RES_VALID=0, RES_CH=0, RES_PERIOD=0, RES_TIMEOUT=0; all counters, accumulator and latched mask are cleared. Reset mid-sweep abandons the sweep and drops any pending result.
- States: IDLE, FIND, CLEAR, SETTLE, DISCARD, ACCUM, EMIT.
- IDLE: CNT_RST_N=0. START=1 -> latch CH_MASK, BUSY=1, go to FIND.
- FIND: select the lowest set bit of the remaining mask at or above the current index.
  - None remaining -> DONE=1 for one cycle, BUSY=0, go to IDLE.
  - A START with mask 0 therefore gives DONE two cycles after START.
  - Found channel -> SEL=channel, go to CLEAR.
- CLEAR: CNT_RST_N=0 for exactly 2 cycles; clear the edge-detect register, edge count, accumulator and timeout counter. Then go to SETTLE.
- SETTLE: CNT_RST_N=1; wait SETTLE_CYCLES cycles, then go to DISCARD. Edges during SETTLE are ignored.
- Edge detect: fall = prev==1 && FREQ_SEL==0; prev <= FREQ_SEL every cycle. PERIOD is sampled on the cycle after fall is detected, because the counter updates PERIOD on the same edge.
- DISCARD: count falls; after DISCARD falls go to ACCUM.
- ACCUM: acc (32+AVG_LOG2 bits) += sampled PERIOD; after 2^AVG_LOG2 samples, RES_PERIOD = acc >> AVG_LOG2 (truncating), RES_TIMEOUT=0, go to EMIT.
- Timeout: in DISCARD/ACCUM the timeout counter increments each cycle and clears on each fall. On reaching TIMEOUT: RES_PERIOD=0, RES_TIMEOUT=1, go to EMIT.
- EMIT: RES_VALID=1, RES_CH=SEL. RES_VALID, RES_CH, RES_PERIOD and RES_TIMEOUT hold stable until RES_VALID && RES_READY.
  - On handshake: RES_VALID=0 next cycle, clear the channel's mask bit, go to FIND.
  - Backpressure stalls the sweep indefinitely; the counter keeps running.
- A fall and a timeout in the same cycle: the fall wins and the timeout counter clears.
- A fall detected on the last cycle of ACCUM's sample count is not used.

Decomposition:
- Shared package: state encoding enum (IDLE..EMIT), CLEAR_CYCLES=2, and the clog2-based CH_W helper.
- Sub-module freq_edge_detect: prev register plus fall pulse plus one-cycle-delayed sample strobe. Reused by other readout blocks.
- Priority find-first-set over the mask is a function within the main module.

Test Plan:
- Mask 8'b0000_0101, channel 0 = 10 high/10 low, channel 2 = 25/25, RES_READY=1 -> results (ch0, 20, TO=0) then (ch2, 50, TO=0), then a DONE pulse, BUSY low.
- Mask 8'b0000_0010, channel 1 jitter: periods 20, 21, 22, 23 after discard -> RES_PERIOD = 86>>2 = 21.
- Mask 8'b1000_0000, channel 7 stuck low, TIMEOUT=100 -> (ch7, 0, TO=1) within DISCARD+CLEAR+SETTLE+100 cycles.
- RES_READY=0 for 50 cycles during EMIT -> outputs stable, SEL unchanged, no second result; RES_READY=1 -> one handshake, sweep resumes.
- Mask 0 -> DONE two cycles after START, no RES_VALID; a START while BUSY is ignored (mask unchanged, single DONE).
- RST asserted during ACCUM -> next cycle all outputs at reset values; a new START sweeps cleanly from channel 0.
